// File: rtl/host_cmd_pkg.sv
// Shared constants, frame layout and state encoding for the host command path.
package host_cmd_pkg;

  localparam int W_WORD      = 16;
  localparam int N_CHAN      = 8;
  localparam int W_WR_ADDR   = 16;
  localparam int W_WR_CHAN   = 16;
  localparam int W_WR_DATA   = 48;
  localparam int TIMEOUT_CYC = 1024;

  localparam int N_DW        = (W_WR_DATA + W_WORD - 1) / W_WORD;
  localparam int FRAME_WORDS = 2 + N_DW;
  localparam int SLOT_ADDR   = 0;
  localparam int SLOT_CHAN   = 1;
  localparam int W_DBUF      = N_DW * W_WORD;
  localparam int W_DIDX      = (N_DW > 1) ? $clog2(N_DW) : 1;

  localparam int ERR_BAD_CHAN = 0;
  localparam int ERR_TIMEOUT  = 1;

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_CHAN  = 2'd1,
    S_DATA  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Clearable saturating cycle counter; o_tc is high while the count equals LIMIT.
module cmd_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W_CNT = $clog2(LIMIT + 1);

  logic [W_CNT-1:0] r_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != W_CNT'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == W_CNT'(LIMIT));

endmodule

// File: rtl/host_wr_master.sv
// Assembles five-word host frames (addr, chan, data low/mid/high) into one
// registered write strobe; drops bad-channel and stalled frames with sticky flags.
module host_wr_master
  import host_cmd_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 cmd_dv_in,
  input  logic [W_WORD-1:0]    cmd_word_in,
  output logic                 cmd_rdy_out,
  input  logic                 err_clr_in,
  output logic                 wr_en,
  output logic [W_WR_ADDR-1:0] wr_addr,
  output logic [W_WR_CHAN-1:0] wr_chan,
  output logic [W_WR_DATA-1:0] wr_data,
  output logic [15:0]          wr_count_out,
  output logic [1:0]           err_out,
  output state_t               dbg_state_out
);

  localparam logic [W_DIDX-1:0] LAST_DIDX = W_DIDX'(N_DW - 1);

  // Handshake: a word transfers on every rising edge where cmd_dv_in and
  // cmd_rdy_out are both high; dv without ready is simply ignored, never held.
  state_t                 r_state, w_next_state;
  logic                   r_rdy;
  logic [W_WR_ADDR-1:0]   r_addr_asm;
  logic [W_WR_CHAN-1:0]   r_chan_asm;
  logic [W_DBUF-1:0]      r_data_buf;
  logic [W_DIDX-1:0]      r_didx;
  logic                   r_drop;
  logic                   r_wr_en;
  logic [W_WR_ADDR-1:0]   r_wr_addr;
  logic [W_WR_CHAN-1:0]   r_wr_chan;
  logic [W_WR_DATA-1:0]   r_wr_data;
  logic [15:0]            r_count;
  logic [1:0]             r_err;

  logic                   w_accept, w_in_frame, w_tc, w_timeout;
  logic                   w_last, w_issue, w_bad;
  logic [W_DBUF-1:0]      w_frame_data;
  logic [1:0]             w_err_next;

  assign w_accept   = cmd_dv_in && r_rdy;
  assign w_in_frame = (r_state == S_CHAN) || (r_state == S_DATA);
  assign w_timeout  = w_in_frame && w_tc;

  cmd_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_clr    (w_accept || !w_in_frame),
    .i_en     (w_in_frame),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_ADDR;
    else           r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ADDR:  if (w_accept) w_next_state = S_CHAN;
      S_CHAN:  if (w_timeout) w_next_state = S_ADDR;
               else if (w_accept) w_next_state = S_DATA;
      S_DATA:  if (w_timeout) w_next_state = S_ADDR;
               else if (w_accept && (r_didx == LAST_DIDX)) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_ADDR;
      default: w_next_state = S_ADDR;
    endcase
  end

  // Issue effects are registered on the last-word edge so they are visible in S_ISSUE.
  always_comb begin
    w_last       = (r_state == S_DATA) && w_accept && !w_timeout && (r_didx == LAST_DIDX);
    w_issue      = w_last && !r_drop;
    w_bad        = w_last && r_drop;
    w_frame_data = r_data_buf;
    w_frame_data[(N_DW-1)*W_WORD +: W_WORD] = cmd_word_in;
    w_err_next   = r_err;
    if (err_clr_in) w_err_next = 2'b00;
    if (w_bad)      w_err_next[ERR_BAD_CHAN] = 1'b1;
    if (w_timeout)  w_err_next[ERR_TIMEOUT]  = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_addr_asm <= '0;
      r_chan_asm <= '0;
      r_data_buf <= '0;
      r_didx     <= '0;
      r_drop     <= 1'b0;
    end else if (w_timeout || (r_state == S_ISSUE)) begin
      r_didx <= '0;
      r_drop <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        S_ADDR: r_addr_asm <= cmd_word_in[W_WR_ADDR-1:0];
        S_CHAN: begin
          r_chan_asm <= cmd_word_in[W_WR_CHAN-1:0];
          r_drop     <= (cmd_word_in >= W_WORD'(N_CHAN));
          r_didx     <= '0;
        end
        S_DATA: begin
          r_data_buf[int'(r_didx)*W_WORD +: W_WORD] <= cmd_word_in;
          r_didx <= r_didx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rdy     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_chan <= '0;
      r_wr_data <= '0;
      r_count   <= '0;
      r_err     <= '0;
    end else begin
      r_rdy   <= (w_next_state != S_ISSUE);
      r_wr_en <= w_issue;
      r_err   <= w_err_next;
      if (w_issue) begin
        r_wr_addr <= r_addr_asm;
        r_wr_chan <= r_chan_asm;
        r_wr_data <= w_frame_data[W_WR_DATA-1:0];
        r_count   <= r_count + 16'd1;
      end
    end
  end

  assign cmd_rdy_out   = r_rdy;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_chan       = r_wr_chan;
  assign wr_data       = r_wr_data;
  assign wr_count_out  = r_count;
  assign err_out       = r_err;
  assign dbg_state_out = r_state;

endmodule

// File: doc/host_wr_master.md
# host_wr_master

Host-side initiator for the configuration write bus (`wr_en` / `wr_addr` / `wr_chan` / `wr_data`) consumed by the PID filter and the other channel-indexed processing blocks. It accepts a stream of 16-bit host command words with a valid/ready handshake and assembles each five-word frame: address, channel, then data low/mid/high. For each frame it issues exactly one single-cycle write strobe. Malformed frames are dropped and flagged: out-of-range channel, or a stalled partial frame.

## Interface
- `W_WORD`, 16, host command word width
- `N_CHAN`, 8, number of valid channels; a channel word ≥ N_CHAN is illegal
- `W_WR_ADDR`, 16, write address width (≤ W_WORD)
- `W_WR_CHAN`, 16, write channel width (≤ W_WORD)
- `W_WR_DATA`, 48, write data width; N_DW = ceil(W_WR_DATA/W_WORD) data words (3)
- `TIMEOUT_CYC`, 1024, idle cycles allowed between words inside a frame
- `clk_in` input 1 — sole clock, all logic rising-edge
- `rst_n_in` input 1 — asynchronous, active-low reset
- `cmd_dv_in` input 1 — host word valid
- `cmd_word_in` input W_WORD — host word
- `cmd_rdy_out` output 1 — block can accept a word; reset 0, then 1 from first clock after release
- `err_clr_in` input 1 — clears `err_out`
- `wr_en` output 1 — single-cycle write strobe; reset 0
- `wr_addr` output W_WR_ADDR — reset 0
- `wr_chan` output W_WR_CHAN — reset 0
- `wr_data` output W_WR_DATA — reset 0
- `wr_count_out` output 16 — writes issued, wraps at 2^16; reset 0
- `err_out` output 2 — sticky: bit0 bad channel, bit1 timeout; reset 0

## Operation
- Word accepted on cycle where `cmd_dv_in && cmd_rdy_out`. `cmd_dv_in` without ready is ignored; no buffering.
- States:
  - S_ADDR: accepted word → addr register (low W_WR_ADDR bits) → S_CHAN.
  - S_CHAN: accepted word → chan register. If the value ≥ N_CHAN, set drop flag. → S_DATA, data index k=0.
  - S_DATA: word k → data bits [W_WORD·k+W_WORD-1 : W_WORD·k], with the top word truncated to W_WR_DATA. k increments each word; after word N_DW-1 → S_ISSUE.
  - S_ISSUE: `cmd_rdy_out`=0. If drop flag is clear, pulse `wr_en`, load `wr_addr`/`wr_chan`/`wr_data` from the assembled registers, and increment `wr_count_out`. If drop flag is set, no strobe, no count, and set `err_out[0]`. Clear drop flag → S_ADDR.
- `wr_addr`/`wr_chan`/`wr_data` change only on an issued write and hold between writes. A downstream block must only sample them with `wr_en`.
- Timeout:
  - Counter clears on every accepted word and increments each cycle in S_CHAN/S_DATA.
  - Reaching TIMEOUT_CYC → discard partial frame, set `err_out[1]`, → S_ADDR.
  - No timeout in S_ADDR or S_ISSUE.
- `err_clr_in` clears both bits; an error set in the same cycle wins.
- Upper bits of the addr/chan words beyond W_WR_ADDR/W_WR_CHAN are ignored; the channel range check uses the full word.

## Timing
- Last data word accepted at cycle t → `wr_en`=1 at t+1 only, `cmd_rdy_out`=0 at t+1, `cmd_rdy_out`=1 at t+2.
- Peak throughput: one write per N_DW+3 cycles (6).
- All outputs registered; no combinational path from inputs to outputs.
- `rst_n_in` low at any point, including mid-frame or during S_ISSUE:
  - immediately clears state to S_ADDR and all outputs to reset values;
  - clears the partial frame, drop flag, and timeout counter;
  - no strobe is produced for the interrupted frame.
- Timeout fires on the cycle the counter equals TIMEOUT_CYC. A word accepted that same cycle is discarded along with the frame.

## Structure
- Shared package (`host_cmd_pkg`):
  - W_WORD, frame layout constants (word count 2+N_DW, ADDR/CHAN slot indices);
  - err bit indices ERR_BAD_CHAN=0, ERR_TIMEOUT=1;
  - state encoding S_ADDR/S_CHAN/S_DATA/S_ISSUE.
- Endpoint addresses come from the existing `ep_map.vh`; the block does not interpret them.
- One sub-module: `cmd_timeout_ctr`, a clearable saturating counter with a terminal-count flag. Everything else lives in the top.

## Test plan
- Good frame, dv held high: words 0x0003, 0x0002, 0x1234, 0x5678, 0x9ABC → one `wr_en` at t+1; `wr_addr`=0x0003, `wr_chan`=2, `wr_data`=0x9ABC_5678_1234; `wr_count_out`=1; `cmd_rdy_out` low exactly one cycle.
- Bad channel: chan word 0x0008, N_CHAN=8 → no `wr_en`, `wr_*` hold prior values, `err_out`=2'b01, count unchanged. The next good frame writes normally.
- Timeout: send addr and chan words, then idle 1024 cycles → `err_out[1]`=1, state S_ADDR. Next five words form a fresh frame and write correctly.
- Gapped handshake: random 0–20-cycle gaps between words of 10 frames → 10 strobes, data matches, no errors.
- Reset mid-frame: after 3 words, pulse `rst_n_in` low asynchronously between clock edges → outputs zero immediately, no strobe. A subsequent full frame writes.
- `err_clr_in` asserted the same cycle a bad-channel frame issues → `err_out[0]` remains 1. Clear on the following cycle → 0.
